// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
//   Bit-serial adder/subtractor. A single full-adder cell is iterated LSB
//   first over WIDTH clocks. This gives the result of a WIDTH-bit ripple
//   carry adder, plus a subtract mode, carry/overflow flags and a
//   start/busy/done handshake.
//
//   Optional build macro: SERIAL_ADDSUB_ACCUM_EN
//     When defined, the extra input 'acc' selects the current sum register
//     as operand A. This turns the block into a running accumulator.
//
// Parameters
//   WIDTH    operand/result width in bits (2..32)
//
// Ports
//   CLOCK_50 in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   request, sampled only in IDLE or DONE
//   sub      in   0 = a+b, 1 = a-b (sampled with start)
//   acc      in   (macro only) take operand A from sum (sampled with start)
//   a, b     in   operands (sampled with start)
//   busy     out  operation in progress
//   done     out  one-cycle pulse when sum/cout/ovf update
//   sum      out  registered result, modulo 2^WIDTH
//   cout     out  carry out of MSB (for sub: 1 = no borrow)
//   ovf      out  signed overflow
// ---------------------------------------------------------------------------
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
`ifdef SERIAL_ADDSUB_ACCUM_EN
  input  logic             acc,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_count;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH-1:0] w_opa_load;

  // One full-adder cell working on the current LSBs.
  assign w_s = r_opa[0] ^ r_opb[0] ^ r_carry;
  assign w_c = (r_opa[0] & r_opb[0]) | (r_opa[0] & r_carry) | (r_opb[0] & r_carry);

  // The new sum bit enters at the MSB, so after WIDTH steps bit 0 sits in place.
  assign w_res_next = {w_s, {(WIDTH-1){1'b0}}} | (r_res >> 1);
  assign w_last     = (r_count == CW'(WIDTH - 1));

`ifdef SERIAL_ADDSUB_ACCUM_EN
  assign w_opa_load = acc ? r_sum : a;
`else
  assign w_opa_load = a;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and evaluation order inside the block is irrelevant.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_count <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
            r_opa   <= w_opa_load;
            r_opb   <= b ^ {WIDTH{sub}};
            r_carry <= sub;
            r_count <= '0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_opa   <= r_opa >> 1;
          r_opb   <= r_opb >> 1;
          r_res   <= w_res_next;
          r_carry <= w_c;
          r_count <= r_count + CW'(1);
          if (w_last) begin
            // Before this edge, r_carry holds the carry into the MSB.
            r_sum   <= w_res_next;
            r_cout  <= w_c;
            r_ovf   <= r_carry ^ w_c;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub
//   Self-checking bench for serial_addsub at WIDTH=8. Expected results come
//   from a reference model that uses plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_serial_addsub;

  localparam int W = 8;

  logic         CLOCK_50 = 1'b0;
  logic         rst      = 1'b1;
  logic         start    = 1'b0;
  logic         sub      = 1'b0;
  logic         acc      = 1'b0;
  logic [W-1:0] a        = '0;
  logic [W-1:0] b        = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int           checks = 0;
  int           errors = 0;

  logic [W-1:0] exp_sum   = '0;
  logic         exp_cout  = 1'b0;
  logic         exp_ovf   = 1'b0;
  logic [W-1:0] model_acc = '0;  // model of the sum register (accumulate mode)

  serial_addsub #(.WIDTH(W)) dut (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
`ifdef SERIAL_ADDSUB_ACCUM_EN
    .acc      (acc),
`endif
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model: integer arithmetic, checked against signed range.
  function automatic void model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                input logic isub, output logic [W-1:0] s,
                                output logic c, output logic v);
    int ua = int'(ia);
    int ub = int'(ib);
    int sa = int'($signed(ia));
    int sb = int'($signed(ib));
    int sr;
    if (!isub) begin
      s  = W'(ua + ub);
      c  = (ua + ub) > 255;
      sr = sa + sb;
    end else begin
      s  = W'(ua - ub);
      c  = (ua >= ub);
      sr = sa - sb;
    end
    v = (sr > 127) || (sr < -128);
  endfunction

  // Drive a request (called just after a falling edge) and set expectations.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub);
    logic [W-1:0] eff_a;
    a = ia; b = ib; sub = isub; start = 1'b1;
    eff_a = ia;
`ifdef SERIAL_ADDSUB_ACCUM_EN
    if (acc) eff_a = model_acc;
`endif
    model(eff_a, ib, isub, exp_sum, exp_cout, exp_ovf);
  endtask

  // Follow an accepted request through RUN. During RUN the inputs are
  // scrambled and start is toggled, and all of this must be ignored.
  // The task then checks the completion cycle.
  task automatic complete(input string tag);
    int busy_cycles = 0;
    @(negedge CLOCK_50);                      // E0 has sampled the request
    for (int j = 0; j < W; j++) begin
      if (busy === 1'b1 && done === 1'b0) busy_cycles++;
      start = (j < W - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      sub   = 1'($urandom);
      @(negedge CLOCK_50);
    end
    check({tag, " busy_cycles"}, 32'(busy_cycles), 32'(W));
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, " sum"}, {24'd0, sum}, {24'd0, exp_sum});
    check({tag, " cout"}, {31'd0, cout}, {31'd0, exp_cout});
    check({tag, " ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
    model_acc = exp_sum;
  endtask

  // After completion without a new request, the block returns to IDLE.
  task automatic expect_idle(input string tag);
    @(negedge CLOCK_50);
    check({tag, " done_pulse_end"}, {31'd0, done}, 32'd0);
    check({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, " sum_hold"}, {24'd0, sum}, {24'd0, exp_sum});
  endtask

  task automatic op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                    input logic isub);
    issue(ia, ib, isub);
    complete(tag);
    expect_idle(tag);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " busy"}, {31'd0, busy}, 32'd0);
    check({tag, " done"}, {31'd0, done}, 32'd0);
    check({tag, " sum"},  {24'd0, sum},  32'd0);
    check({tag, " cout"}, {31'd0, cout}, 32'd0);
    check({tag, " ovf"},  {31'd0, ovf},  32'd0);
  endtask

  initial begin
    // Reset, with start held high: reset must win.
    start = 1'b1; a = 8'h12; b = 8'h34;
    repeat (3) @(negedge CLOCK_50);
    check_cleared("reset");
    start = 1'b0;
    rst   = 1'b0;
    @(negedge CLOCK_50);
    check("post_reset_idle", {31'd0, busy}, 32'd0);

    // Directed vectors.
    op("add_3c_05", 8'h3C, 8'h05, 1'b0);
    op("add_7f_01", 8'h7F, 8'h01, 1'b0);
    op("add_ff_01", 8'hFF, 8'h01, 1'b0);
    op("sub_05_07", 8'h05, 8'h07, 1'b1);
    op("sub_80_01", 8'h80, 8'h01, 1'b1);

    // Back-to-back: new request presented in each DONE cycle.
    issue(8'h11, 8'h22, 1'b0);
    complete("b2b_0");
    issue(8'hF0, 8'h20, 1'b0);
    complete("b2b_1");
    issue(8'h01, 8'h02, 1'b1);
    complete("b2b_2");
    expect_idle("b2b_end");

    // Randomized operations.
    for (int k = 0; k < 20; k++) begin
      op("rand", W'($urandom), W'($urandom), 1'($urandom));
    end

    // Reset four clocks into RUN: outputs must clear without a clock edge.
    issue(8'h55, 8'h33, 1'b0);
    @(negedge CLOCK_50);
    start = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1 check_cleared("async_reset");
    model_acc = '0;
    @(negedge CLOCK_50);
    rst = 1'b0;
    @(negedge CLOCK_50);
    op("after_reset_10_20", 8'h10, 8'h20, 1'b0);

`ifdef SERIAL_ADDSUB_ACCUM_EN
    rst = 1'b1;
    @(negedge CLOCK_50);
    rst = 1'b0;
    model_acc = '0;
    @(negedge CLOCK_50);
    acc = 1'b1;
    op("acc_1", 8'hAA, 8'h05, 1'b0);
    op("acc_2", 8'hAA, 8'h05, 1'b0);
    op("acc_3", 8'hAA, 8'h05, 1'b0);
    op("acc_dec", 8'hAA, 8'h10, 1'b1);
    acc = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
